// File: rtl/muldiv.sv
// Iterative 32x32 multiply / divide unit: 32 shift-add or restoring shift-subtract steps
// on operand magnitudes, with sign correction applied when the result is written.
module muldiv (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  OP,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        div_zero
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]  state;
    logic [5:0]  count;
    logic        is_div;
    logic        b_zero;
    logic        neg_main;
    logic        neg_rem;
    logic [31:0] a_raw;
    logic [31:0] mag;
    logic [31:0] work_hi;
    logic [31:0] work_lo;

    logic        signed_op;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [31:0] div_diff;
    logic        div_ge;
    logic [31:0] iter_hi;
    logic [31:0] iter_lo;
    logic [63:0] product;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign signed_op = ~OP[0];
    assign a_abs     = (signed_op && A[31]) ? -A : A;
    assign b_abs     = (signed_op && B[31]) ? -B : B;

    // Multiply: {work_hi, work_lo} is the product register, multiplier shifted out of work_lo.
    // Divide: work_hi is the partial remainder, work_lo shifts dividend out and quotient in.
    always_comb begin
        mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, mag} : 33'd0);
        div_shift = {work_hi, work_lo[31]};
        div_ge    = (div_shift >= {1'b0, mag});
        div_diff  = div_shift[31:0] - mag;
        if (is_div) begin
            iter_hi = div_ge ? div_diff : div_shift[31:0];
            iter_lo = {work_lo[30:0], div_ge};
        end else begin
            iter_hi = mul_sum[32:1];
            iter_lo = {mul_sum[0], work_lo[31:1]};
        end
    end

    always_comb begin
        product = neg_main ? -{work_hi, work_lo} : {work_hi, work_lo};
        if (is_div) begin
            if (b_zero) begin
                res_hi = a_raw;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_hi = neg_rem  ? -work_hi : work_hi;
                res_lo = neg_main ? -work_lo : work_lo;
            end
        end else begin
            res_hi = product[63:32];
            res_lo = product[31:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= StIdle;
            count    <= 6'd0;
            is_div   <= 1'b0;
            b_zero   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            a_raw    <= 32'd0;
            mag      <= 32'd0;
            work_hi  <= 32'd0;
            work_lo  <= 32'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            HI       <= 32'd0;
            LO       <= 32'd0;
        end else begin
            case (state)
                StIdle, StDone: begin
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                    if (start) begin
                        state    <= StRun;
                        busy     <= 1'b1;
                        count    <= 6'd0;
                        is_div   <= OP[1];
                        b_zero   <= (B == 32'd0);
                        a_raw    <= A;
                        neg_main <= signed_op && (A[31] ^ B[31]);
                        neg_rem  <= signed_op && A[31];
                        mag      <= OP[1] ? b_abs : a_abs;
                        work_hi  <= 32'd0;
                        work_lo  <= OP[1] ? a_abs : b_abs;
                    end else begin
                        state <= StIdle;
                    end
                end
                StRun: begin
                    if (count != 6'd32) begin
                        count   <= count + 6'd1;
                        work_hi <= iter_hi;
                        work_lo <= iter_lo;
                    end else begin
                        state    <= StDone;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        div_zero <= is_div && b_zero;
                        HI       <= res_hi;
                        LO       <= res_lo;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: directed cases, randomized operations against an
// arithmetic reference model, start-ignore, back-to-back and reset-abort scenarios.
module tb_muldiv;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  OP = 2'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    muldiv dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .OP       (OP),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .HI       (HI),
        .LO       (LO),
        .div_zero (div_zero)
    );

    logic [1:0]  t_op [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd2};
    logic [31:0] t_a  [7] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd100, 32'd100,
                              32'h80000000, 32'hFFFFFFF0};
    logic [31:0] t_b  [7] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd2, 32'd7, 32'd0,
                              32'hFFFFFFFF, 32'd0};
    logic [31:0] t_hi [7] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd2, 32'd100,
                              32'd0, 32'hFFFFFFF0};
    logic [31:0] t_lo [7] = '{32'hFFFFFFEB, 32'h00000001, 32'hFFFFFFFD, 32'd14, 32'hFFFFFFFF,
                              32'h80000000, 32'hFFFFFFFF};
    logic        t_dz [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reference result {div_zero, HI, LO} from plain arithmetic.
    function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        logic [31:0] q;
        logic [31:0] r;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'd0: begin
                p = sa * sb;
                return {1'b0, p};
            end
            2'd1: begin
                p = {32'd0, a} * {32'd0, b};
                return {1'b0, p};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
                if (op == 2'd2) begin
                    q = 32'(sa / sb);
                    r = 32'(sa % sb);
                end else begin
                    q = a / b;
                    r = a % b;
                end
                return {1'b0, r, q};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    // Start is sampled at the next rising edge (edge k); returns #1 after it with inputs scrambled.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        start = 1'b1;
        OP = op;
        A = a;
        B = b;
        @(posedge clock);
        #1;
        start = 1'b0;
        OP = 2'($urandom);
        A = $urandom;
        B = $urandom;
    endtask

    task automatic to_edge(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] a;
        logic [31:0] b;
        logic [64:0] exp;
        start = 1'b1;
        OP = 2'd1;
        A = $urandom;
        B = $urandom;
        to_edge(3);
        n_cmp++;
        if ({busy, done, div_zero, HI, LO} !== 67'd0) begin
            n_err++;
            $display("FAIL reset_state: got %h, expected 0", {busy, done, div_zero, HI, LO});
        end
        a = $urandom;
        b = $urandom;
        exp = model(2'd1, a, b);
        @(negedge clock);
        reset = 1'b0;
        OP = 2'd1;
        A = a;
        B = b;
        @(posedge clock);
        #1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL first_start_busy: got %b, expected 1", busy);
        end
        to_edge(33);
        n_cmp++;
        if ({done, busy, div_zero, HI, LO} !== {2'b10, exp}) begin
            n_err++;
            $display("FAIL first_start_result: got %h, expected %h",
                     {done, busy, div_zero, HI, LO}, {2'b10, exp});
        end
    endtask

    task automatic test_directed();
        for (int i = 0; i < 7; i++) begin
            launch(t_op[i], t_a[i], t_b[i]);
            n_cmp++;
            if ({busy, done} !== 2'b10) begin
                n_err++;
                $display("FAIL directed_busy[%0d]: got %b, expected 10", i, {busy, done});
            end
            to_edge(32);
            n_cmp++;
            if ({busy, done} !== 2'b10) begin
                n_err++;
                $display("FAIL directed_early[%0d]: got %b, expected 10", i, {busy, done});
            end
            to_edge(1);
            n_cmp++;
            if ({busy, done, div_zero} !== {2'b01, t_dz[i]}) begin
                n_err++;
                $display("FAIL directed_flags[%0d]: got %b, expected %b", i,
                         {busy, done, div_zero}, {2'b01, t_dz[i]});
            end
            n_cmp++;
            if ({HI, LO} !== {t_hi[i], t_lo[i]}) begin
                n_err++;
                $display("FAIL directed_result[%0d]: got %h, expected %h", i, {HI, LO},
                         {t_hi[i], t_lo[i]});
            end
            to_edge(1);
            n_cmp++;
            if ({busy, done, div_zero, HI, LO} !== {3'b000, t_hi[i], t_lo[i]}) begin
                n_err++;
                $display("FAIL directed_after[%0d]: got %h, expected %h", i,
                         {busy, done, div_zero, HI, LO}, {3'b000, t_hi[i], t_lo[i]});
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [64:0] exp;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            a = pick_operand();
            b = pick_operand();
            exp = model(op, a, b);
            launch(op, a, b);
            to_edge(33);
            n_cmp++;
            if ({done, busy, div_zero, HI, LO} !== {2'b10, exp}) begin
                n_err++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h, expected %h", i, op, a, b,
                         {done, busy, div_zero, HI, LO}, {2'b10, exp});
            end
            to_edge(1);
            OP = 2'($urandom);
            A = $urandom;
            B = $urandom;
            to_edge(2);
            n_cmp++;
            if ({done, busy, HI, LO} !== {2'b00, exp[63:0]}) begin
                n_err++;
                $display("FAIL idle_hold[%0d]: got %h, expected %h", i, {done, busy, HI, LO},
                         {2'b00, exp[63:0]});
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] a;
        logic [31:0] b;
        logic [64:0] exp;
        a = $urandom;
        b = $urandom;
        exp = model(2'd0, a, b);
        launch(2'd0, a, b);
        to_edge(4);
        start = 1'b1;
        OP = 2'd3;
        A = ~a;
        B = 32'd3;
        to_edge(1);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL ignore_busy: got %b, expected 1", busy);
        end
        to_edge(27);
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_early: got done=%b, expected 0", done);
        end
        to_edge(1);
        n_cmp++;
        if ({done, busy, div_zero, HI, LO} !== {2'b10, exp}) begin
            n_err++;
            $display("FAIL ignore_result: got %h, expected %h", {done, busy, div_zero, HI, LO},
                     {2'b10, exp});
        end
        to_edge(1);
        n_cmp++;
        if ({done, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL ignore_after: got %b, expected 00", {done, busy});
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  op1;
        logic [1:0]  op2;
        logic [31:0] a2;
        logic [31:0] b2;
        logic [64:0] exp1;
        logic [64:0] exp2;
        logic [31:0] a1;
        logic [31:0] b1;
        op1 = 2'd2;
        a1 = $urandom;
        b1 = $urandom_range(1, 1000);
        op2 = 2'd1;
        a2 = $urandom;
        b2 = $urandom;
        exp1 = model(op1, a1, b1);
        exp2 = model(op2, a2, b2);
        launch(op1, a1, b1);
        to_edge(33);
        n_cmp++;
        if ({done, busy, div_zero, HI, LO} !== {2'b10, exp1}) begin
            n_err++;
            $display("FAIL b2b_first: got %h, expected %h", {done, busy, div_zero, HI, LO},
                     {2'b10, exp1});
        end
        start = 1'b1;
        OP = op2;
        A = a2;
        B = b2;
        to_edge(1);
        start = 1'b0;
        A = $urandom;
        B = $urandom;
        n_cmp++;
        if ({done, busy} !== 2'b01) begin
            n_err++;
            $display("FAIL b2b_accept: got %b, expected 01", {done, busy});
        end
        to_edge(32);
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_early: got done=%b, expected 0", done);
        end
        to_edge(1);
        n_cmp++;
        if ({done, busy, div_zero, HI, LO} !== {2'b10, exp2}) begin
            n_err++;
            $display("FAIL b2b_second: got %h, expected %h", {done, busy, div_zero, HI, LO},
                     {2'b10, exp2});
        end
        to_edge(1);
    endtask

    task automatic test_reset_abort();
        logic [31:0] a;
        logic [31:0] b;
        logic [64:0] exp;
        logic        seen_done;
        launch(2'd0, 32'd12345, 32'hFFFF0000);
        to_edge(10);
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, div_zero, HI, LO} !== 67'd0) begin
            n_err++;
            $display("FAIL abort_clear: got %h, expected 0", {busy, done, div_zero, HI, LO});
        end
        @(negedge clock);
        reset = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            to_edge(1);
            if (done === 1'b1) seen_done = 1'b1;
        end
        n_cmp++;
        if (seen_done !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_done: got %b, expected 0", seen_done);
        end
        a = $urandom;
        b = $urandom;
        exp = model(2'd0, a, b);
        launch(2'd0, a, b);
        to_edge(33);
        n_cmp++;
        if ({done, busy, div_zero, HI, LO} !== {2'b10, exp}) begin
            n_err++;
            $display("FAIL abort_next: got %h, expected %h", {done, busy, div_zero, HI, LO},
                     {2'b10, exp});
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
